fifo_word_packer: RTL

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer_pkg.sv | 21 ++
 rtl/fifo_word_packer_if.sv | 38 +++
 rtl/fifo_word_packer_out_reg.sv | 75 +++++++
 rtl/fifo_word_packer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the FIFO word packer: default widths, FSM state
// encoding and the partial-word keep-mask helper.
package fifo_pkg;

   localparam int PKG_DATA_W = 8;
   localparam int PKG_LANES  = 4;

   typedef enum logic [1:0] {
      ST_FILL       = 2'd0,
      ST_FLUSH_WAIT = 2'd1,
      ST_FLUSH_EMIT = 2'd2
   } pk_state_e;

   // Mask with the low n bits set; n may be 0..8 (8 lanes max).
   function automatic logic [7:0] keep_mask(input logic [3:0] n);
      logic [8:0] one_hot;
      one_hot = 9'd1 << n;
      return 8'(one_hot - 9'd1);
   endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bus bundle for the packer: upstream FIFO pop side, flush control and the
// packed output stream. m_parity exists only when PACKER_PARITY_EN is defined.
interface fifo_word_packer_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
);
   logic                      fifo_empty;
   logic                      fifo_rd_en;
   logic [DATA_W-1:0]         fifo_data;
   logic                      flush;
   logic                      m_valid;
   logic                      m_ready;
   logic [DATA_W*LANES-1:0]   m_data;
   logic [LANES-1:0]          m_keep;
   logic                      m_last;
   logic                      flush_done;
`ifdef PACKER_PARITY_EN
   logic [LANES-1:0]          m_parity;

   modport master (
      input  fifo_empty, fifo_data, flush, m_ready,
      output fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done, m_parity
   );
   modport slave (
      output fifo_empty, fifo_data, flush, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done, m_parity
   );
`else
   modport master (
      input  fifo_empty, fifo_data, flush, m_ready,
      output fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done
   );
   modport slave (
      output fifo_empty, fifo_data, flush, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done
   );
`endif
endinterface

// File: rtl/fifo_word_packer_out_reg.sv
// Output holding register for the packer. Holds the word stable under
// backpressure and reports when a new word may be loaded. Per-byte even
// parity is registered alongside the data when PACKER_PARITY_EN is defined.
module packer_out_reg
   import fifo_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int LANES  = PKG_LANES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_i,
   input  logic [LANES-1:0][DATA_W-1:0]   data_i,
   input  logic [LANES-1:0]               keep_i,
   input  logic                           last_i,
   input  logic                           ready_i,
   output logic                           valid_o,
   output logic [DATA_W*LANES-1:0]        data_o,
   output logic [LANES-1:0]               keep_o,
   output logic                           last_o,
`ifdef PACKER_PARITY_EN
   output logic [LANES-1:0]               parity_o,
`endif
   output logic                           slot_free_o
);

   logic                    valid_q;
   logic [DATA_W*LANES-1:0] data_q;
   logic [LANES-1:0]        keep_q;
   logic                    last_q;

   // Slot is free when empty or its current word leaves this cycle.
   assign slot_free_o = !valid_q || ready_i;

   // Load a new word or retire the current one on handshake; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         keep_q  <= keep_i;
         last_q  <= last_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

`ifdef PACKER_PARITY_EN
   logic [LANES-1:0] par_d, par_q;

   // Even parity of each incoming byte.
   always_comb begin
      par_d = '0;
      for (int i = 0; i < LANES; i++) par_d[i] = ^data_i[i];
   end

   // Parity travels with the data it covers.
   always_ff @(posedge clk) begin
      if (rst)         par_q <= '0;
      else if (load_i) par_q <= par_d;
   end

   assign parity_o = par_q;
`endif

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign keep_o  = keep_q;
   assign last_o  = last_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Packs bytes popped from an upstream FIFO into LANES-byte words. A flush
// pulse emits the partial word (marked last) after any in-flight byte lands.
// Optional feature: define PACKER_PARITY_EN to add per-byte m_parity.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int LANES  = PKG_LANES
) (
   input logic               clk,
   input logic               rst,
   fifo_word_packer_if.master bus
);

   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES);

   localparam logic [1:0] FILL       = ST_FILL;
   localparam logic [1:0] FLUSH_WAIT = ST_FLUSH_WAIT;
   localparam logic [1:0] FLUSH_EMIT = ST_FLUSH_EMIT;

   logic [1:0]                    state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          inflight_q;
   logic [LANES-1:0][DATA_W-1:0]  acc_q, acc_d;
   logic                          flush_done_q;

   logic                          pop;
   logic [CNT_W-1:0]              occ;
   logic                          slot_free;
   logic                          load;
   logic [LANES-1:0][DATA_W-1:0]  ld_data;
   logic [LANES-1:0]              ld_keep;
   logic                          ld_last;
   logic [7:0]                    km;

   // Lanes already filled plus the one byte that may still be on its way.
   assign occ = cnt_q + CNT_W'(inflight_q);
   assign pop = !rst && !bus.fifo_empty && (state_q == FILL) && (occ < FULL);
   assign bus.fifo_rd_en = pop;
   assign bus.flush_done = flush_done_q;

   // Capture arriving bytes, run the flush FSM and decide what to load.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      load    = 1'b0;
      ld_data = acc_q;
      ld_keep = '0;
      ld_last = 1'b0;
      km      = keep_mask(4'(cnt_q));

      if (inflight_q) begin
         acc_d[cnt_q[IDX_W-1:0]] = bus.fifo_data;
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         FILL: begin
            // A flush takes over a full word so it goes out marked last.
            if (bus.flush) begin
               state_d = FLUSH_WAIT;
            end else if (cnt_q == FULL && slot_free) begin
               load    = 1'b1;
               ld_keep = '1;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         FLUSH_WAIT: begin
            if (!inflight_q && slot_free) state_d = FLUSH_EMIT;
         end
         FLUSH_EMIT: begin
            if (cnt_q != '0) begin
               load    = 1'b1;
               ld_keep = km[LANES-1:0];
               ld_last = 1'b1;
            end
            cnt_d   = '0;
            acc_d   = '0;
            state_d = FILL;
         end
         default: state_d = FILL;
      endcase

      for (int i = 0; i < LANES; i++) begin
         if (!ld_keep[i]) ld_data[i] = '0;
      end
   end

   // State, lane count, accumulator and in-flight tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         acc_q        <= '0;
         inflight_q   <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         inflight_q   <= pop;
         flush_done_q <= (state_q == FLUSH_EMIT);
      end
   end

   packer_out_reg #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_out (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .data_i      (ld_data),
      .keep_i      (ld_keep),
      .last_i      (ld_last),
      .ready_i     (bus.m_ready),
      .valid_o     (bus.m_valid),
      .data_o      (bus.m_data),
      .keep_o      (bus.m_keep),
      .last_o      (bus.m_last),
`ifdef PACKER_PARITY_EN
      .parity_o    (bus.m_parity),
`endif
      .slot_free_o (slot_free)
   );

endmodule
